// File: rtl/gpio_host_sequencer.sv
// ---------------------------------------------------------------------------
// gpio_host_sequencer
//
// Fabric-side command initiator for the trigger/ADC GPIO controller. One
// command handshake is expanded into the select-word sequence the controller
// expects: a function word held for HOLD cycles, an idle/settle gap of SETTLE
// cycles, an inquiry sample, or a burst of FIFO reads where each word is
// acknowledged with a single-cycle pop edge on SELECT_out[2].
//
// Ports:
//   sys_clk     system clock
//   _RESET_in   asynchronous active-low reset
//   cmd_valid   command request
//   cmd_ready   high only while idle; accept = cmd_valid & cmd_ready
//   cmd_op      opcode (0 start, 1 inquiry, 2 read, 3 stop, 4-7 trigger
//               levels, 8 clock divider, 9 shaping, 10-15 illegal)
//   cmd_arg     operand
//   SELECT_out  command word: [15:0] function code, [31:16] data
//   GPIO_in     controller return word
//   rd_data     FIFO word read, valid while rd_valid
//   rd_valid    held until rd_ready
//   rd_ready    downstream accept
//   fifo_cnt    FIFO count from the last inquiry, decremented per pop
//   fifo_full   FIFO full flag from the last inquiry
//   sleeping    controller sleep state
//   done        one-cycle pulse when a command completes
//   cmd_err     raised with done for an illegal opcode
// ---------------------------------------------------------------------------
module gpio_host_sequencer #(
    parameter int HOLD   = 2,
    parameter int SETTLE = 2
) (
    input  logic        sys_clk,
    input  logic        _RESET_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_arg,
    output logic [31:0] SELECT_out,
    input  logic [31:0] GPIO_in,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [15:0] fifo_cnt,
    output logic        fifo_full,
    output logic        sleeping,
    output logic        done,
    output logic        cmd_err
);

    localparam logic [15:0] HOLD_LAST   = 16'(HOLD - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

    localparam logic [3:0] OP_START       = 4'd0;
    localparam logic [3:0] OP_INQ         = 4'd1;
    localparam logic [3:0] OP_READ        = 4'd2;
    localparam logic [3:0] OP_STOP        = 4'd3;
    localparam logic [3:0] OP_FIRST_ILLEG = 4'd10;

    localparam logic [31:0] SLEEP_WORD = 32'h0000_0008;
    localparam logic [31:0] POP_BIT    = 32'h0000_0004;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_GAP     = 3'd2,
        ST_INQ     = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_OUT  = 3'd5,
        ST_RD_POP  = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    state_t      state_r;
    logic [3:0]  op_r;
    logic [31:0] word_r;
    logic [15:0] cnt_r;
    logic [15:0] left_r;

    logic [31:0] idle_word_s;
    logic [31:0] word_s;
    logic [15:0] burst_len_s;

    // Function word for an opcode; the read and illegal opcodes have none.
    function automatic logic [31:0] encode_word(input logic [3:0] op, input logic [15:0] arg);
        logic [31:0] w;
        case (op)
            4'd0:    w = 32'h0000_0001;
            4'd1:    w = 32'h0000_0002;
            4'd3:    w = 32'h0000_0008;
            4'd4:    w = {2'b00, arg[13:0], 16'h0010};
            4'd5:    w = {2'b00, arg[13:0], 16'h0020};
            4'd6:    w = {2'b00, arg[13:0], 16'h0040};
            4'd7:    w = {2'b00, arg[13:0], 16'h0080};
            4'd8:    w = {8'h00, arg[7:4], arg[3:0], 16'h0100};
            4'd9:    w = {4'h0, arg[11:0], 16'h0200};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Idle word, requested word and burst length derived from current inputs.
    always_comb begin
        idle_word_s = 32'h0000_0000;
        burst_len_s = 16'h0000;
        word_s      = encode_word(cmd_op, cmd_arg);
        if (sleeping) begin
            idle_word_s = SLEEP_WORD;
        end else begin
            idle_word_s = 32'h0000_0000;
        end
        // Never read past what the last inquiry reported.
        if (cmd_arg < fifo_cnt) begin
            burst_len_s = cmd_arg;
        end else begin
            burst_len_s = fifo_cnt;
        end
    end

    // Command sequencer: state, counters and all registered outputs.
    always_ff @(posedge sys_clk or negedge _RESET_in) begin
        if (!_RESET_in) begin
            state_r    <= ST_IDLE;
            op_r       <= 4'd0;
            word_r     <= 32'h0000_0000;
            cnt_r      <= 16'h0000;
            left_r     <= 16'h0000;
            cmd_ready  <= 1'b1;
            SELECT_out <= 32'h0000_0000;
            rd_data    <= 32'h0000_0000;
            rd_valid   <= 1'b0;
            fifo_cnt   <= 16'h0000;
            fifo_full  <= 1'b0;
            sleeping   <= 1'b0;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_r      <= cmd_op;
                        word_r    <= word_s;
                        cmd_err   <= 1'b0;
                        cmd_ready <= 1'b0;
                        if (cmd_op == OP_READ) begin
                            if (burst_len_s == 16'h0000) begin
                                state_r <= ST_DONE;
                            end else begin
                                left_r  <= burst_len_s;
                                cnt_r   <= SETTLE_LAST;
                                state_r <= ST_RD_WAIT;
                            end
                        end else if (cmd_op >= OP_FIRST_ILLEG) begin
                            state_r <= ST_DONE;
                        end else begin
                            SELECT_out <= word_s;
                            cnt_r      <= HOLD_LAST;
                            state_r    <= ST_DRIVE;
                            if (cmd_op == OP_START) begin
                                sleeping <= 1'b0;
                            end else if (cmd_op == OP_STOP) begin
                                sleeping <= 1'b1;
                            end
                        end
                    end else begin
                        SELECT_out <= idle_word_s;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r == 16'h0000) begin
                        cnt_r   <= SETTLE_LAST;
                        state_r <= ST_GAP;
                        // Inquiry keeps its word up so the return word settles.
                        SELECT_out <= (op_r == OP_INQ) ? word_r : idle_word_s;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == 16'h0000) begin
                        if (op_r == OP_INQ) begin
                            state_r <= ST_INQ;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_INQ: begin
                    fifo_cnt   <= GPIO_in[15:0];
                    fifo_full  <= GPIO_in[16];
                    SELECT_out <= idle_word_s;
                    state_r    <= ST_DONE;
                end
                ST_RD_WAIT: begin
                    if (cnt_r == 16'h0000) begin
                        rd_data  <= GPIO_in;
                        rd_valid <= 1'b1;
                        state_r  <= ST_RD_OUT;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_RD_OUT: begin
                    if (rd_ready) begin
                        rd_valid   <= 1'b0;
                        SELECT_out <= idle_word_s | POP_BIT;
                        state_r    <= ST_RD_POP;
                    end
                end
                ST_RD_POP: begin
                    // Dropping bit2 here guarantees a fresh rising edge per word.
                    SELECT_out <= idle_word_s;
                    fifo_cnt   <= (fifo_cnt == 16'h0000) ? 16'h0000 : fifo_cnt - 16'd1;
                    left_r     <= left_r - 16'd1;
                    if (left_r > 16'd1) begin
                        cnt_r   <= SETTLE_LAST;
                        state_r <= ST_RD_WAIT;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done       <= 1'b1;
                    cmd_err    <= (op_r >= OP_FIRST_ILLEG);
                    cmd_ready  <= 1'b1;
                    SELECT_out <= idle_word_s;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cmd_ready  <= 1'b1;
                    rd_valid   <= 1'b0;
                    SELECT_out <= idle_word_s;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gpio_host_sequencer
//
// Directed plus randomized bench for gpio_host_sequencer. A small model of
// the GPIO controller supplies GPIO_in (inquiry word or FIFO contents that
// advance on each rising pop edge), and a command-level reference model keeps
// the expected sleep state, FIFO count/full flag and per-cycle select words.
// ---------------------------------------------------------------------------
module tb_gpio_host_sequencer;

    localparam int H = 2;
    localparam int S = 2;

    logic        sys_clk;
    logic        _RESET_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic [31:0] SELECT_out;
    logic [31:0] GPIO_in;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] fifo_cnt;
    logic        fifo_full;
    logic        sleeping;
    logic        done;
    logic        cmd_err;

    gpio_host_sequencer #(.HOLD(H), .SETTLE(S)) dut (
        .sys_clk    (sys_clk),
        ._RESET_in  (_RESET_in),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .SELECT_out (SELECT_out),
        .GPIO_in    (GPIO_in),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_cnt   (fifo_cnt),
        .fifo_full  (fifo_full),
        .sleeping   (sleeping),
        .done       (done),
        .cmd_err    (cmd_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] mem [0:63];
    int          head;
    logic [31:0] trace [$];
    logic [31:0] beats [$];
    int          pops;
    int          done_idx;
    int          cnt_m;
    bit          full_m;
    bit          sleep_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Function word from the opcode table, built arithmetically.
    function automatic logic [31:0] model_word(input logic [3:0] op, input logic [15:0] arg);
        logic [31:0] a;
        a = {16'd0, arg};
        if (op == 4'd0) return 32'h1;
        if (op == 4'd1) return 32'h2;
        if (op == 4'd3) return 32'h8;
        if (op >= 4'd4 && op <= 4'd7) return ((a & 32'h3FFF) << 16) | (32'h10 << (op - 4'd4));
        if (op == 4'd8) return ((a & 32'hFF) << 16) | 32'h100;
        if (op == 4'd9) return ((a & 32'hFFF) << 16) | 32'h200;
        return 32'h0;
    endfunction

    // Issue one command and record SELECT_out per cycle until done (bounded).
    task automatic run_cmd(input logic [3:0] op, input logic [15:0] arg);
        bit hs_prev;
        bit b2_prev;
        trace.delete();
        beats.delete();
        pops = 0;
        done_idx = -1;
        hs_prev = 1'b0;
        b2_prev = 1'b0;
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_arg = arg;
        @(negedge sys_clk);
        // Keep requesting junk while busy: it must be ignored.
        cmd_op = 4'($urandom);
        cmd_arg = 16'($urandom);
        for (int k = 0; k < 400; k++) begin
            trace.push_back(SELECT_out);
            if (SELECT_out[2]) begin
                pops++;
                chk("pop_after_handshake", 32'(hs_prev), 32'd1);
                chk("pop_isolated", 32'(b2_prev), 32'd0);
                chk("pop_bits_exclusive", 32'(SELECT_out[1:0]), 32'd0);
                if (head < 63) head++;
                GPIO_in = mem[head];
            end
            b2_prev = SELECT_out[2];
            if (done) begin
                done_idx = k;
                break;
            end
            rd_ready = 1'($urandom);
            hs_prev = rd_valid & rd_ready;
            if (hs_prev) beats.push_back(rd_data);
            @(negedge sys_clk);
        end
        cmd_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    // Run a command and check it against the reference model.
    task automatic exec(input logic [3:0] op, input logic [15:0] arg, input bit rand_data);
        logic [31:0] w;
        logic [31:0] idle;
        logic [31:0] inq_word;
        logic [31:0] exp_q [$];
        int n;
        if (op == 4'd1) begin
            if (rand_data) GPIO_in = {15'($urandom), 1'($urandom), 16'($urandom_range(0, 8))};
        end else if (op == 4'd2) begin
            head = 0;
            if (rand_data) begin
                for (int i = 0; i < 64; i++) mem[i] = $urandom;
            end
            GPIO_in = mem[0];
        end else if (rand_data) begin
            GPIO_in = $urandom;
        end
        inq_word = GPIO_in;
        if (op == 4'd0) sleep_m = 1'b0;
        else if (op == 4'd3) sleep_m = 1'b1;
        idle = sleep_m ? 32'h8 : 32'h0;
        w = model_word(op, arg);
        n = (op == 4'd2) ? ((int'(arg) < cnt_m) ? int'(arg) : cnt_m) : 0;

        run_cmd(op, arg);

        if (op == 4'd2 && n > 0) begin
            chk("beat_count", 32'(beats.size()), 32'(n));
            for (int i = 0; i < beats.size() && i < 64; i++) chk("beat_data", beats[i], mem[i]);
            chk("pop_count", 32'(pops), 32'(n));
            chk("read_done_seen", 32'(done_idx >= 0), 32'd1);
            foreach (trace[i]) chk("read_idle_bits", trace[i] & ~32'h4, idle);
        end else begin
            if (op == 4'd1) begin
                repeat (H + S + 1) exp_q.push_back(w);
            end else if (op != 4'd2 && op < 4'd10) begin
                repeat (H) exp_q.push_back(w);
                repeat (S) exp_q.push_back(idle);
            end
            exp_q.push_back(idle);
            exp_q.push_back(idle);
            chk($sformatf("trace_len_op%0d", op), 32'(trace.size()), 32'(exp_q.size()));
            foreach (exp_q[i]) begin
                if (i < trace.size()) chk($sformatf("select_op%0d_c%0d", op, i), trace[i], exp_q[i]);
            end
            chk("no_pop", 32'(pops), 32'd0);
        end

        if (op == 4'd1) begin
            cnt_m = int'(inq_word[15:0]);
            full_m = inq_word[16];
        end else if (op == 4'd2) begin
            cnt_m = cnt_m - n;
        end
        chk("fifo_cnt", 32'(fifo_cnt), 32'(cnt_m));
        chk("fifo_full", 32'(fifo_full), 32'(full_m));
        chk("sleeping", 32'(sleeping), 32'(sleep_m));
        chk("cmd_err", 32'(cmd_err), 32'(op >= 4'd10));
        chk("ready_at_done", 32'(cmd_ready), 32'd1);
        chk("rd_valid_at_done", 32'(rd_valid), 32'd0);
        @(negedge sys_clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        bit saw_pop;
        bit saw_rdv;
        logic [3:0] op;

        _RESET_in = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 4'd0;
        cmd_arg = 16'd0;
        GPIO_in = 32'd0;
        rd_ready = 1'b0;
        head = 0;
        cnt_m = 0;
        full_m = 1'b0;
        sleep_m = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        #1 _RESET_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_select", SELECT_out, 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_fifo_full", 32'(fifo_full), 32'd0);
        chk("rst_sleeping", 32'(sleeping), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        _RESET_in = 1'b1;
        @(negedge sys_clk);

        // Stop then start.
        exec(4'd3, 16'd0, 1'b1);
        chk("stop_word", trace[0], 32'h0000_0008);
        chk("stop_sleeping", 32'(sleeping), 32'd1);
        exec(4'd0, 16'd0, 1'b1);
        chk("start_word", trace[0], 32'h0000_0001);
        chk("start_sleeping", 32'(sleeping), 32'd0);

        // Inquiry.
        GPIO_in = 32'h0001_0005;
        exec(4'd1, 16'd0, 1'b0);
        chk("inq_cnt", 32'(fifo_cnt), 32'd5);
        chk("inq_full", 32'(fifo_full), 32'd1);
        chk("inq_latency", 32'(done_idx), 32'(H + S + 2));

        // Burst of three words, FIFO holds five.
        for (int i = 0; i < 64; i++) mem[i] = 32'hA0 + 32'(i);
        exec(4'd2, 16'd3, 1'b0);
        chk("burst_beats", 32'(beats.size()), 32'd3);
        if (beats.size() == 3) begin
            chk("burst_beat0", beats[0], 32'hA0);
            chk("burst_beat1", beats[1], 32'hA1);
            chk("burst_beat2", beats[2], 32'hA2);
        end
        chk("burst_cnt_end", 32'(fifo_cnt), 32'd2);

        // Empty FIFO read: no pop, no data.
        GPIO_in = 32'h0000_0000;
        exec(4'd1, 16'd0, 1'b0);
        exec(4'd2, 16'd4, 1'b1);
        chk("empty_read_latency", 32'(done_idx), 32'd1);
        chk("empty_read_beats", 32'(beats.size()), 32'd0);

        // Configuration words and an illegal opcode.
        exec(4'd4, 16'hFFFF, 1'b1);
        chk("h_trg1_word", trace[0], 32'h3FFF_0010);
        chk("cfg_latency", 32'(done_idx), 32'(H + S + 1));
        exec(4'd8, 16'h0037, 1'b1);
        chk("clkdiv_word", trace[0], 32'h0037_0100);
        exec(4'd9, 16'hF123, 1'b1);
        chk("shape_word", trace[0], 32'h0123_0200);
        exec(4'd12, 16'h1234, 1'b1);
        chk("illegal_latency", 32'(done_idx), 32'd1);
        exec(4'd5, 16'h0001, 1'b1);
        chk("err_cleared", 32'(cmd_err), 32'd0);

        // Randomized commands, biased toward inquiry/read.
        for (int r = 0; r < 60; r++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(1, 2));
            exec(op, 16'($urandom), 1'b1);
        end

        // Asynchronous reset while a word waits in RD_OUT.
        GPIO_in = 32'h0000_0003;
        exec(4'd1, 16'd0, 1'b0);
        exec(4'd3, 16'd0, 1'b1);
        head = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0 + 32'(i);
        GPIO_in = mem[0];
        rd_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 4'd2;
        cmd_arg = 16'd2;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        saw_pop = 1'b0;
        saw_rdv = 1'b0;
        for (int k = 0; k < 50 && !saw_rdv; k++) begin
            if (SELECT_out[2]) saw_pop = 1'b1;
            if (rd_valid) saw_rdv = 1'b1;
            else @(negedge sys_clk);
        end
        chk("arst_rd_valid_seen", 32'(saw_rdv), 32'd1);
        chk("arst_rd_data", rd_data, 32'hC0);
        #2 _RESET_in = 1'b0;
        #1;
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_select", SELECT_out, 32'h0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_sleeping", 32'(sleeping), 32'd0);
        chk("arst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        repeat (2) begin
            @(negedge sys_clk);
            if (SELECT_out[2]) saw_pop = 1'b1;
        end
        chk("arst_no_pop", 32'(saw_pop), 32'd0);
        _RESET_in = 1'b1;
        cnt_m = 0;
        full_m = 1'b0;
        sleep_m = 1'b0;
        @(negedge sys_clk);
        exec(4'd2, 16'd5, 1'b1);
        exec(4'd0, 16'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
